// File: rtl/nms_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nms_frame_ctrl
// Purpose  : Frame sequencer for the Canny NMS stage. Generates start/clken/
//            border flags and tracks results in flight until the frame drains.
//            Optional macro NMS_FRAME_STATS_EN adds frame_cnt / err_cnt ports.
// Revision : 1.0 - initial release
// ============================================================================
module nms_frame_ctrl #(
    parameter int WIDTH       = 634,
    parameter int DEPTH       = 506,
    parameter int KERNEL_SIZE = 3,
    parameter int PIPE_LAT    = 16,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic        out_en,
    output logic        nms_start,
    output logic        nms_clken,
    output logic        nms_invalid,
    output logic        busy,
    output logic        frame_done,
    output logic        drain_err
`ifdef NMS_FRAME_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
`endif
);

    localparam int c_TMR_W = $clog2(PIPE_LAT + 1);
    localparam int c_ISS_W = 2 * CNT_W;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FILL  = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_LAST_COL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_LAST_ROW = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_BORDER   = CNT_W'(KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0]   c_FILL_ROW = CNT_W'(KERNEL_SIZE - 2);
    localparam logic [c_ISS_W-1:0] c_ISS_ONE  = c_ISS_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LD   = c_TMR_W'(PIPE_LAT);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_col;
    logic [CNT_W-1:0]   r_row;
    logic [c_ISS_W-1:0] r_issued;
    logic [c_ISS_W-1:0] r_done;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_nms_start;
    logic               r_nms_clken;
    logic               r_nms_invalid;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_drain_err;

    logic               w_active;
    logic               w_pix;
    logic               w_last_col;
    logic               w_invalid;
    logic               w_cnt_en;
    logic               w_extra;
    logic               w_done_inc;
    logic [c_ISS_W-1:0] w_done_next;

    assign w_active    = (r_state == c_FILL) || (r_state == c_RUN);
    assign w_pix       = pix_valid && w_active;
    assign w_last_col  = (r_col == c_LAST_COL);
    assign w_invalid   = (r_row < c_BORDER) || (r_col < c_BORDER);
    assign w_cnt_en    = out_en && (w_active || (r_state == c_DRAIN));
    // A result arriving when nothing is outstanding is spurious: flag, do not count.
    assign w_extra     = w_cnt_en && (r_done == r_issued);
    assign w_done_inc  = w_cnt_en && !w_extra;
    assign w_done_next = w_done_inc ? (r_done + c_ISS_ONE) : r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_issued      <= '0;
            r_done        <= '0;
            r_timer       <= '0;
            r_nms_start   <= 1'b0;
            r_nms_clken   <= 1'b0;
            r_nms_invalid <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_drain_err   <= 1'b0;
        end else begin
            r_nms_clken   <= 1'b0;
            r_nms_invalid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_done        <= w_done_next;
            if (w_extra) r_drain_err <= 1'b1;

            if (w_pix) begin
                r_nms_clken   <= 1'b1;
                r_nms_invalid <= w_invalid;
                if (!w_invalid) r_issued <= r_issued + c_ISS_ONE;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= (r_row == c_LAST_ROW) ? '0 : (r_row + c_CNT_ONE);
                end else begin
                    r_col <= r_col + c_CNT_ONE;
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (frame_start) begin
                        r_state     <= c_FILL;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_issued    <= '0;
                        r_done      <= '0;
                        r_drain_err <= 1'b0;
                        r_nms_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                c_FILL: begin
                    if (w_pix && w_last_col && (r_row == c_FILL_ROW)) r_state <= c_RUN;
                end
                c_RUN: begin
                    if (w_pix && w_last_col && (r_row == c_LAST_ROW)) begin
                        r_state <= c_DRAIN;
                        r_timer <= c_TMR_LD;
                    end
                end
                c_DRAIN: begin
                    if (w_done_next == r_issued) begin
                        r_state      <= c_DONE;
                        r_nms_start  <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else if (out_en) begin
                        r_timer <= c_TMR_LD;
                    end else if (r_timer <= c_TMR_ONE) begin
                        // Timer would hit zero with results still missing.
                        r_state      <= c_DONE;
                        r_nms_start  <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_drain_err  <= 1'b1;
                    end else begin
                        r_timer <= r_timer - c_TMR_ONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_busy      <= 1'b0;
                    r_nms_start <= 1'b0;
                end
            endcase
        end
    end

    assign nms_start   = r_nms_start;
    assign nms_clken   = r_nms_clken;
    assign nms_invalid = r_nms_invalid;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign drain_err   = r_drain_err;

`ifdef NMS_FRAME_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    // DONE lasts exactly one cycle per completed frame; drain_err is final there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (r_state == c_DONE) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if (r_drain_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nms_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nms_frame_ctrl
// Purpose  : Scoreboard bench for nms_frame_ctrl on an 8x6 frame, 3x3 kernel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nms_frame_ctrl;

    localparam int c_W  = 8;
    localparam int c_D  = 6;
    localparam int c_K  = 3;
    localparam int c_PL = 16;
    localparam int c_NPIX = c_W * c_D;

    logic clk = 1'b0;
    logic rst, frame_start, pix_valid, out_en;
    logic nms_start, nms_clken, nms_invalid, busy, frame_done, drain_err;
`ifdef NMS_FRAME_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    nms_frame_ctrl #(
        .WIDTH(c_W), .DEPTH(c_D), .KERNEL_SIZE(c_K), .PIPE_LAT(c_PL), .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .out_en(out_en), .nms_start(nms_start), .nms_clken(nms_clken),
        .nms_invalid(nms_invalid), .busy(busy), .frame_done(frame_done),
        .drain_err(drain_err)
`ifdef NMS_FRAME_STATS_EN
        , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed { int cyc; logic inv; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int cyc = 0;
    int fd_cnt = 0, fd_cyc = 0, clk_cnt = 0, val_cnt = 0;

    // Monitor: pops the expected window flag whenever the DUT presents nms_clken.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (nms_clken === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_clken", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("clken_latency", cyc, mon_e.cyc);
                check("nms_invalid", {31'd0, nms_invalid}, {31'd0, mon_e.inv});
                clk_cnt++;
                if (nms_invalid === 1'b0) val_cnt++;
            end
        end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            check("clken_missing", 0, 1);
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    // Result-echo model: each valid window returns out_en exactly PIPE_LAT edges later.
    logic [c_PL-1:0] sr = '0;
    int  oe_left = 0;
    int  last_oe_cyc = 0;
    bit  drop_last = 0;
    bit  pix_done = 0;

    task automatic step(input logic pv, input logic win, input logic acc, input logic fs);
        @(negedge clk);
        pix_valid   = pv;
        frame_start = fs;
        out_en      = sr[c_PL-1] && !(drop_last && pix_done && oe_left == 1);
        if (sr[c_PL-1]) begin
            if (out_en) last_oe_cyc = cyc + 1;
            oe_left--;
        end
        sr = {sr[c_PL-2:0], pv & win};
        if (pv & win) oe_left++;
        if (pv && acc) sb_q.push_back('{cyc: cyc + 1, inv: !win});
    endtask

    task automatic run_frame(input bit gaps, input bit drop, input int fs_pix, input int fs_drain);
        int fd0, ck0, vl0, row, col;
        logic win;
        fd0 = fd_cnt; ck0 = clk_cnt; vl0 = val_cnt;
        drop_last = drop; pix_done = 0;
        step(0, 0, 0, 1);
        @(posedge clk); #1;
        check("busy_in_frame", {31'd0, busy}, 1);
        check("nms_start_in_frame", {31'd0, nms_start}, 1);
        for (int n = 0; n < c_NPIX; n++) begin
            if (gaps && $urandom_range(0, 1) == 1) step(0, 0, 0, 0);
            row = n / c_W; col = n % c_W;
            win = (row >= c_K - 1) && (col >= c_K - 1);
            step(1, win, 1, (n == fs_pix) ? 1'b1 : 1'b0);
        end
        pix_done = 1;
        for (int i = 0; i < 100 && fd_cnt == fd0; i++)
            step(0, 0, 0, (i == fs_drain) ? 1'b1 : 1'b0);
        check("frame_done_seen", fd_cnt - fd0, 1);
        check("frame_done_time", fd_cyc, drop ? last_oe_cyc + c_PL : last_oe_cyc);
        repeat (6) step(0, 0, 0, 0);
        check("frame_done_once", fd_cnt - fd0, 1);
        check("clken_count", clk_cnt - ck0, c_NPIX);
        check("valid_windows", val_cnt - vl0, (c_W - c_K + 1) * (c_D - c_K + 1));
        check("drain_err", {31'd0, drain_err}, {31'd0, drop});
        check("busy_after", {31'd0, busy}, 0);
        check("nms_start_after", {31'd0, nms_start}, 0);
        check("scoreboard_empty", sb_q.size(), 0);
        drop_last = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; frame_start = 0; pix_valid = 0; out_en = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_nms_start", {31'd0, nms_start}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_drain_err", {31'd0, drain_err}, 0);
        rst = 0;
        // Strobes in IDLE must be ignored.
        pix_valid = 1; out_en = 1;
        repeat (3) @(negedge clk);
        pix_valid = 0; out_en = 0;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_nms_start", {31'd0, nms_start}, 0);
        check("idle_drain_err", {31'd0, drain_err}, 0);

        run_frame(0, 0, -1, -1);
        run_frame(1, 0, -1, -1);
        run_frame(0, 1, -1, -1);
        run_frame(0, 0, 30, 3);

        // Reset mid-frame at row 3.
        begin
            int fd0;
            fd0 = fd_cnt;
            step(0, 0, 0, 1);
            for (int n = 0; n < 3 * c_W + 2; n++)
                step(1, ((n / c_W) >= c_K - 1) && ((n % c_W) >= c_K - 1), 1, 0);
            @(negedge clk);
            rst = 1; pix_valid = 0; out_en = 0;
            @(negedge clk);
            rst = 0;
            sr = '0; oe_left = 0;
            check("midrst_busy", {31'd0, busy}, 0);
            check("midrst_nms_start", {31'd0, nms_start}, 0);
            check("midrst_drain_err", {31'd0, drain_err}, 0);
            repeat (20) step(0, 0, 0, 0);
            check("midrst_no_frame_done", fd_cnt - fd0, 0);
            check("midrst_scoreboard", sb_q.size(), 0);
        end

        run_frame(0, 0, -1, -1);
        run_frame(1, 0, -1, -1);
        run_frame(0, 0, -1, -1);
`ifdef NMS_FRAME_STATS_EN
        check("frame_cnt", {16'd0, frame_cnt}, 3);
        check("err_cnt", {24'd0, err_cnt}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
